// File: rtl/axi_w_drain_pkg.sv
// Shared types for the AXI W-channel drain: FSM state encoding and default burst-length width.
package axi_tb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BURST     = 2'd1,
    WAIT_LAST = 2'd2
  } state_t;

  localparam int LENW_DEFAULT = 8;

endpackage

// File: rtl/axi_w_drain.sv
// Drains one burst of words from an upstream FIFO onto an AXI4 W channel, one register stage.
// Optional FIFO-starvation counter enabled by defining AXI_W_DRAIN_UNDERRUN_EN.
module axi_w_drain
  import axi_tb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LENW  = LENW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LENW-1:0]    cmd_len,
  input  logic [WIDTH/8-1:0] cmd_strb,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_rdata,
  output logic               fifo_read,
  output logic [WIDTH-1:0]   m_wdata,
  output logic [WIDTH/8-1:0] m_wstrb,
  output logic               m_wlast,
  output logic               m_wvalid,
  input  logic               m_wready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        underrun_cnt
);

  localparam int SW = WIDTH / 8;
  localparam logic [LENW:0] ONE = {{LENW{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [LENW:0]    pops_left_q, pops_left_d;
  logic [SW-1:0]    strb_q, strb_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]    wstrb_q, wstrb_d;
  logic             wlast_q, wlast_d;
  logic             wvalid_q, wvalid_d;
  logic             done_q, done_d;
  logic             hs;

  assign hs = wvalid_q & m_wready;

  // A pop is only issued when the output register is free or being emptied this cycle.
  always_comb begin
    fifo_read = (state_q == BURST) && !fifo_empty && (pops_left_q != '0) &&
                (!wvalid_q || m_wready) && !reset;
  end

  always_comb begin
    state_d     = state_q;
    pops_left_d = pops_left_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wlast_d     = wlast_q;
    wvalid_d    = wvalid_q;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          pops_left_d = {1'b0, cmd_len} + ONE;
          strb_d      = cmd_strb;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (fifo_read && pops_left_q == ONE) state_d = WAIT_LAST;
      end
      WAIT_LAST: begin
        if (hs && wlast_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_read) begin
      wdata_d     = fifo_rdata;
      wstrb_d     = strb_q;
      wlast_d     = (pops_left_q == ONE);
      wvalid_d    = 1'b1;
      pops_left_d = pops_left_q - ONE;
    end else if (hs) begin
      wvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pops_left_q <= '0;
      strb_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wlast_q     <= 1'b0;
      wvalid_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pops_left_q <= pops_left_d;
      strb_q      <= strb_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wlast_q     <= wlast_d;
      wvalid_q    <= wvalid_d;
      done_q      <= done_d;
    end
  end

  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign m_wlast  = wlast_q;
  assign m_wvalid = wvalid_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

`ifdef AXI_W_DRAIN_UNDERRUN_EN
  logic [15:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (state_q == BURST && pops_left_q != '0 && fifo_empty && underrun_q != 16'hFFFF)
      underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) underrun_q <= '0;
    else       underrun_q <= underrun_d;
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_axi_w_drain.sv
// Randomized bench for axi_w_drain: a queue-based FIFO and a beat-count reference model
// predict pops, W beats, done, busy and the starvation count cycle by cycle.
module tb_axi_w_drain;

  localparam int WIDTH = 32;
  localparam int LENW  = 8;
  localparam int SW    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LENW-1:0]  cmd_len = '0;
  logic [SW-1:0]    cmd_strb = '0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             fifo_read;
  logic [WIDTH-1:0] m_wdata;
  logic [SW-1:0]    m_wstrb;
  logic             m_wlast;
  logic             m_wvalid;
  logic             m_wready = 1'b0;
  logic             busy;
  logic             done;
  logic [15:0]      underrun_cnt;

  axi_w_drain #(.WIDTH(WIDTH), .LENW(LENW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_strb(cmd_strb),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_read(fifo_read),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .busy(busy), .done(done), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ur_model = 0;
  logic [WIDTH-1:0] fifo_q[$];

`ifdef AXI_W_DRAIN_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  // Generic burst engine: cycle 0 offers the command, then models pops/beats until done.
  task automatic run_burst(input int len, input int rdy_pct, input int empty_pct,
                           input int stall_beat, input int stall_cyc,
                           input int gap_after, input int gap_cyc,
                           input int abort_hs, input bit use_w0,
                           input logic [WIDTH-1:0] w0, output int last_hs_out);
    logic [SW-1:0]    strb;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] w;
    int remaining = 0, pops = 0, hs = 0, cyc = 0, last_hs = -10;
    int stall_used = 0, gap_used = 0, pending;
    bit fin = 0, e, r, exp_rd, exp_busy;
    strb = SW'($urandom);
    for (int i = 0; i <= len; i++) begin
      w = (i == 0 && use_w0) ? w0 : WIDTH'($urandom);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    fifo_q.push_back(WIDTH'($urandom));
    fifo_q.push_back(WIDTH'($urandom));
    while (!fin) begin
      @(negedge clk);
      pending = pops - hs;
      if (abort_hs >= 0 && hs >= abort_hs) begin
        reset = 1'b1; cmd_valid = 1'b0; fifo_empty = 1'b0; fifo_rdata = fifo_q[0]; m_wready = 1'b1;
        #1;
        checks++;
        if (fifo_read !== 1'b0) begin errors++; $display("FAIL rst_no_pop: fifo_read=%b required 0", fifo_read); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (m_wvalid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || underrun_cnt !== 16'h0) begin
          errors++;
          $display("FAIL rst_mid_burst: wvalid=%b busy=%b cmd_ready=%b done=%b ur=%0d required 0 0 1 0 0",
                   m_wvalid, busy, cmd_ready, done, underrun_cnt);
        end
        fifo_q.delete();
        ur_model = 0;
        last_hs_out = -1;
        return;
      end
      cmd_valid = (cyc == 0);
      cmd_len   = LENW'(len);
      cmd_strb  = strb;
      e = (fifo_q.size() == 0) || ($urandom_range(99) < empty_pct);
      if (gap_cyc > 0 && pops >= gap_after && gap_used < gap_cyc) begin e = 1'b1; gap_used++; end
      r = ($urandom_range(99) < rdy_pct);
      if (pending > 0 && hs == stall_beat && stall_used < stall_cyc) begin r = 1'b0; stall_used++; end
      fifo_empty = e;
      fifo_rdata = e ? WIDTH'($urandom) : fifo_q[0];
      m_wready   = r;
      #1;
      exp_rd   = (remaining > 0) && !e && (pending == 0 || r);
      exp_busy = (cyc > 0) && (last_hs < 0 || cyc <= last_hs);
      checks++;
      if (fifo_read !== exp_rd) begin errors++; $display("FAIL fifo_read c%0d: got %b required %b", cyc, fifo_read, exp_rd); end
      checks++;
      if (m_wvalid !== (pending > 0)) begin errors++; $display("FAIL m_wvalid c%0d: got %b required %b", cyc, m_wvalid, pending > 0); end
      if (pending > 0) begin
        checks++;
        if (m_wdata !== exp_q[hs] || m_wstrb !== strb || m_wlast !== (hs == len)) begin
          errors++;
          $display("FAIL beat%0d: data=%h strb=%h last=%b required %h %h %b",
                   hs, m_wdata, m_wstrb, m_wlast, exp_q[hs], strb, hs == len);
        end
      end
      checks++;
      if (done !== (cyc == last_hs + 1)) begin errors++; $display("FAIL done c%0d: got %b required %b", cyc, done, cyc == last_hs + 1); end
      checks++;
      if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
        errors++;
        $display("FAIL busy_ready c%0d: busy=%b cmd_ready=%b required %b %b", cyc, busy, cmd_ready, exp_busy, !exp_busy);
      end
      if (fifo_read === 1'b1 && !e && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (remaining > 0 && e && ur_model < 65535) ur_model++;
      if (pending > 0 && r) begin hs++; if (hs == len + 1) last_hs = cyc; end
      if (exp_rd) begin pops++; remaining--; end
      if (cyc == 0) remaining = len + 1;
      if (cyc == last_hs + 1) fin = 1;
      cyc++;
      if (cyc > 4000) begin
        checks++; errors++;
        $display("FAIL timeout: burst len %0d stuck after %0d beats, required %0d", len, hs, len + 1);
        fin = 1;
      end
    end
    checks++;
    if (fifo_q.size() != 2) begin errors++; $display("FAIL pop_count: words left %0d required 2", fifo_q.size()); end
    checks++;
    if (underrun_cnt !== (UR_EN ? 16'(ur_model) : 16'h0)) begin
      errors++; $display("FAIL underrun_cnt: got %0d required %0d", underrun_cnt, UR_EN ? ur_model : 0);
    end
    fifo_q.delete();
    last_hs_out = last_hs;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0; fifo_empty = 1'b1; m_wready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ur_model = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset = 1'b1; cmd_valid = 1'b1; cmd_len = LENW'($urandom);
      fifo_empty = 1'b0; fifo_rdata = WIDTH'($urandom); m_wready = 1'($urandom);
      #1;
      checks++;
      if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_pop: fifo_read=%b required 0", fifo_read); end
    end
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0; fifo_empty = 1'b1;
    #1;
    checks++;
    if (m_wvalid !== 1'b0 || m_wlast !== 1'b0 || m_wdata !== '0 || m_wstrb !== '0 ||
        done !== 1'b0 || busy !== 1'b0 || underrun_cnt !== 16'h0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: wv=%b wl=%b wd=%h ws=%h done=%b busy=%b ur=%0d rdy=%b required all 0, cmd_ready 1",
               m_wvalid, m_wlast, m_wdata, m_wstrb, done, busy, underrun_cnt, cmd_ready);
    end
    ur_model = 0;
  endtask

  task automatic test_basic();
    int lh;
    run_burst(3, 100, 0, -1, 0, 0, 0, -1, 1'b0, '0, lh);
    checks++;
    if (lh != 5) begin errors++; $display("FAIL basic_latency: last beat cycle %0d required 5", lh); end
  endtask

  task automatic test_single_beat();
    int lh;
    run_burst(0, 100, 0, -1, 0, 0, 0, -1, 1'b1, 32'h55, lh);
    checks++;
    if (lh != 2) begin errors++; $display("FAIL single_latency: last beat cycle %0d required 2", lh); end
  endtask

  task automatic test_stall();
    int lh;
    run_burst(7, 100, 0, 2, 3, 0, 0, -1, 1'b0, '0, lh);
    checks++;
    if (lh != 12) begin errors++; $display("FAIL stall_latency: last beat cycle %0d required 12", lh); end
  endtask

  task automatic test_underrun();
    int lh;
    do_reset();
    run_burst(4, 100, 0, -1, 0, 1, 5, -1, 1'b0, '0, lh);
    checks++;
    if (underrun_cnt !== (UR_EN ? 16'd5 : 16'd0)) begin
      errors++; $display("FAIL underrun_five: got %0d required %0d", underrun_cnt, UR_EN ? 5 : 0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int lh;
    run_burst(7, 100, 0, -1, 0, 0, 0, 2, 1'b0, '0, lh);
    run_burst(1, 100, 0, -1, 0, 0, 0, -1, 1'b0, '0, lh);
    checks++;
    if (lh != 3) begin errors++; $display("FAIL post_reset_burst: last beat cycle %0d required 3", lh); end
  endtask

  task automatic test_max_len();
    int lh;
    run_burst(255, 100, 0, -1, 0, 0, 0, -1, 1'b0, '0, lh);
    checks++;
    if (lh != 257) begin errors++; $display("FAIL max_len_throughput: last beat cycle %0d required 257", lh); end
  endtask

  task automatic test_back_to_back();
    int lh;
    for (int i = 0; i < 12; i++)
      run_burst($urandom_range(20), $urandom_range(40, 100), $urandom_range(0, 50),
                -1, 0, 0, 0, -1, 1'b0, '0, lh);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_beat();
    test_stall();
    test_underrun();
    test_reset_mid_burst();
    test_max_len();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_w_drain.md
AXI_W_DRAIN -- requirements
Module: axi_w_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning W data width in bits (multiple of 8, 8..1024).
REQ-002 SHALL have parameter LENW, default 8, meaning burst-length field width (AXI4 awlen).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  burst command offered.
REQ-006 SHALL have port cmd_ready  output  1  burst command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_len  input  LENW  beats minus one.
REQ-008 SHALL have port cmd_strb  input  WIDTH/8  strobe applied to every beat of the burst.
REQ-009 SHALL have port fifo_empty  input  1  upstream data FIFO empty flag.
REQ-010 SHALL have port fifo_rdata  input  WIDTH  upstream FIFO head word, combinationally valid while not empty.
REQ-011 SHALL have port fifo_read  output  1  pop request to upstream FIFO.
REQ-012 SHALL have ports m_wdata/m_wstrb/m_wlast/m_wvalid  output  WIDTH/WIDTH/8/1/1  AXI4 W channel.
REQ-013 SHALL have port m_wready  input  1  AXI4 W channel ready.
REQ-014 SHALL have ports busy  output  1  (state not IDLE) and done  output  1  (one-cycle burst-complete pulse).
REQ-015 SHALL have port underrun_cnt  output  16  FIFO-starvation cycle count (see Configuration).

Function
REQ-016 SHALL implement states IDLE, BURST, WAIT_LAST.
REQ-017 IDLE: cmd_ready=1; on cmd_valid load pops_left=cmd_len+1 (LENW+1 bits, no overflow at len=all-ones), latch cmd_strb, go BURST.
REQ-018 cmd_ready SHALL be 0 in BURST and WAIT_LAST.
REQ-019 fifo_read SHALL equal (state==BURST) & !fifo_empty & (pops_left!=0) & (!m_wvalid | m_wready) & !reset.
REQ-020 On fifo_read, next edge SHALL load m_wdata=fifo_rdata, m_wstrb=latched strb, m_wvalid=1, m_wlast=(pops_left==1), pops_left decrements; pop-to-W latency exactly 1 cycle.
REQ-021 Sustained throughput SHALL be 1 beat/cycle with FIFO non-empty and m_wready=1.
REQ-022 m_wvalid SHALL clear after handshake (m_wvalid&m_wready) with no simultaneous pop.
REQ-023 Once m_wvalid=1, m_wdata/m_wstrb/m_wlast SHALL hold stable until handshake (AXI rule).
REQ-024 Pop issuing final beat (pops_left==1) SHALL move BURST->WAIT_LAST.
REQ-025 WAIT_LAST: on handshake with m_wlast=1, go IDLE and assert done for exactly the next cycle; no pops in WAIT_LAST.
REQ-026 FIFO empty mid-burst SHALL stall with no pop and no spurious beat; m_wvalid drops after pending beat accepted.
REQ-027 Back-to-back commands: new cmd accepted no earlier than the cycle after done's triggering handshake (cmd_ready high in IDLE cycle).
REQ-028 cmd_len=0 SHALL yield a single beat with m_wlast=1.

Reset
REQ-029 Reset SHALL force state=IDLE, pops_left=0, m_wvalid=0, m_wlast=0, m_wdata=0, m_wstrb=0, done=0, busy=0, underrun_cnt=0 at next edge.
REQ-030 Reset mid-burst SHALL abandon the burst; fifo_read SHALL be 0 during any cycle reset is high; cmd_ready=1 first cycle after reset deasserts.

Configuration
REQ-031 With macro AXI_W_DRAIN_UNDERRUN_EN defined, underrun_cnt SHALL increment (saturating at 16'hFFFF) each cycle state==BURST & pops_left!=0 & fifo_empty.
REQ-032 Without AXI_W_DRAIN_UNDERRUN_EN, underrun_cnt SHALL be constant 0 and the counter logic absent.

Structure
REQ-033 State enum type and default LENW constant SHALL live in shared package axi_tb_pkg.
REQ-034 Block SHALL be a single module with no sub-module; the upstream FIFO is instantiated by the parent.

Verification
REQ-035 cmd_len=3, FIFO holds 4 words A0..A3, m_wready=1 -> 4 consecutive beats, m_wlast only on A3, done 1 cycle after A3 handshake.
REQ-036 cmd_len=0, one word 0x55 -> single beat 0x55 with m_wlast=1, strb=cmd_strb.
REQ-037 cmd_len=7, m_wready low for 3 cycles on beat 2 -> m_wdata/m_wlast stable throughout, no pop during stall, 8 beats total in order.
REQ-038 cmd_len=4, FIFO empty for 5 cycles after beat 1 -> no extra beats, underrun_cnt=5 with macro defined, 0 without.
REQ-039 Reset asserted after beat 2 of cmd_len=7 -> m_wvalid=0 next cycle, fifo_read=0 during reset, new cmd_len=1 burst then completes correctly.
REQ-040 cmd_len=255 -> exactly 256 beats, m_wlast only on beat 256, pops_left no overflow.
